// File: rtl/wb_load_unit.sv
// ============================================================================
// wb_load_unit : writeback stage merging ALU results with aligned load data
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_wen_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_is_load_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [1:0]  ex_addr_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_wen_o,
  output logic        pend_valid_o,
  output logic [4:0]  pend_rd_o,
  output logic        err_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [2:0] c_F3_LB  = 3'd0;
  localparam logic [2:0] c_F3_LH  = 3'd1;
  localparam logic [2:0] c_F3_LW  = 3'd2;
  localparam logic [2:0] c_F3_LBU = 3'd4;
  localparam logic [2:0] c_F3_LHU = 3'd5;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_rd;
  logic        r_wen;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr;
  logic        r_reg_wen;
  logic [4:0]  r_reg_waddr;
  logic [31:0] r_reg_wdata;
  logic        r_err;

  logic        w_transfer;
  logic        w_load_legal;
  logic        w_latch;
  logic        w_wen_nxt;
  logic [4:0]  w_waddr_nxt;
  logic [31:0] w_wdata_nxt;
  logic        w_err_nxt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign ex_ready_o   = (r_state == IDLE);
  assign w_transfer   = ex_valid_i && ex_ready_o;
  assign pend_valid_o = (r_state == WAIT_MEM);
  assign pend_rd_o    = pend_valid_o ? r_rd : 5'd0;
  assign reg_wen_o    = r_reg_wen;
  assign reg_waddr_o  = r_reg_waddr;
  assign reg_wdata_o  = r_reg_wdata;
  assign err_o        = r_err;

  always_comb begin
    w_load_legal = 1'b0;
    case (ex_funct3_i)
      c_F3_LB, c_F3_LBU: w_load_legal = 1'b1;
      c_F3_LH, c_F3_LHU: w_load_legal = ~ex_addr_i[0];
      c_F3_LW:           w_load_legal = (ex_addr_i == 2'd0);
      default:           w_load_legal = 1'b0;
    endcase
  end

  // Byte/half lane selection uses the address latched at load acceptance
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_addr)
      2'd0: w_byte = mem_rdata_i[7:0];
      2'd1: w_byte = mem_rdata_i[15:8];
      2'd2: w_byte = mem_rdata_i[23:16];
      2'd3: w_byte = mem_rdata_i[31:24];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_funct3)
      c_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_F3_LBU: w_load_data = {24'd0, w_byte};
      c_F3_LHU: w_load_data = {16'd0, w_half};
      default:  w_load_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_wen_nxt   = 1'b0;
    w_waddr_nxt = 5'd0;
    w_wdata_nxt = 32'd0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        // A response with nothing outstanding is dropped and flagged
        if (mem_rvalid_i) begin
          w_err_nxt = 1'b1;
        end
        if (w_transfer) begin
          if (ex_is_load_i) begin
            if (w_load_legal) begin
              w_latch     = 1'b1;
              w_state_nxt = WAIT_MEM;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (ex_wen_i && (ex_rd_i != 5'd0)) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = ex_rd_i;
            w_wdata_nxt = ex_wdata_i;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          w_state_nxt = IDLE;
          if (r_wen && (r_rd != 5'd0)) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = r_rd;
            w_wdata_nxt = w_load_data;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rd        <= 5'd0;
      r_wen       <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 2'd0;
      r_reg_wen   <= 1'b0;
      r_reg_waddr <= 5'd0;
      r_reg_wdata <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_reg_wen   <= w_wen_nxt;
      r_reg_waddr <= w_waddr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_err       <= w_err_nxt;
      if (w_latch) begin
        r_rd     <= ex_rd_i;
        r_wen    <= ex_wen_i;
        r_funct3 <= ex_funct3_i;
        r_addr   <= ex_addr_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_load_unit.sv
// ============================================================================
// tb_wb_load_unit : randomized + directed bench against a behavioural model
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_load_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_i = 5'd0;
  logic        ex_wen_i = 1'b0;
  logic [31:0] ex_wdata_i = 32'd0;
  logic        ex_is_load_i = 1'b0;
  logic [2:0]  ex_funct3_i = 3'd0;
  logic [1:0]  ex_addr_i = 2'd0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;
  logic        pend_valid_o;
  logic [4:0]  pend_rd_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: is a load outstanding, and what it was
  bit          m_busy;
  logic [4:0]  m_rd;
  bit          m_wen;
  logic [2:0]  m_f3;
  logic [1:0]  m_addr;
  bit          e_wen;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  bit          e_err;

  wb_load_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_rd_i      (ex_rd_i),
    .ex_wen_i     (ex_wen_i),
    .ex_wdata_i   (ex_wdata_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_funct3_i  (ex_funct3_i),
    .ex_addr_i    (ex_addr_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wen_o    (reg_wen_o),
    .pend_valid_o (pend_valid_o),
    .pend_rd_o    (pend_rd_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
    if (f3 == 3'd2) return a == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * int'(a))) & 32'hFF);
    h = 16'((w >> (16 * (int'(a) / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // One clock: advance model with the inputs presented, then compare every output
  task automatic cycle();
    @(posedge clk);
    e_wen = 0; e_waddr = 0; e_wdata = 0; e_err = 0;
    if (!rst) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (mem_rvalid_i) e_err = 1;
      if (ex_valid_i) begin
        if (ex_is_load_i) begin
          if (legal(ex_funct3_i, ex_addr_i)) begin
            m_busy = 1; m_rd = ex_rd_i; m_wen = ex_wen_i;
            m_f3 = ex_funct3_i; m_addr = ex_addr_i;
          end else begin
            e_err = 1;
          end
        end else if (ex_wen_i && ex_rd_i != 0) begin
          e_wen = 1; e_waddr = ex_rd_i; e_wdata = ex_wdata_i;
        end
      end
    end else if (mem_rvalid_i) begin
      if (m_wen && m_rd != 0) begin
        e_wen = 1; e_waddr = m_rd; e_wdata = extract(m_f3, m_addr, mem_rdata_i);
      end
      m_busy = 0;
    end
    #1;
    chk("reg_wen",    32'(reg_wen_o),    32'(e_wen));
    chk("reg_waddr",  32'(reg_waddr_o),  32'(e_waddr));
    chk("reg_wdata",  reg_wdata_o,       e_wdata);
    chk("err",        32'(err_o),        32'(e_err));
    chk("ex_ready",   32'(ex_ready_o),   32'(!m_busy));
    chk("pend_valid", 32'(pend_valid_o), 32'(m_busy));
    chk("pend_rd",    32'(pend_rd_o),    m_busy ? 32'(m_rd) : 32'd0);
  endtask

  task automatic idle_in();
    ex_valid_i = 0; ex_is_load_i = 0; ex_wen_i = 0; ex_rd_i = 0;
    ex_wdata_i = 0; ex_funct3_i = 0; ex_addr_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic issue(input bit ld, input logic [4:0] rd, input bit wen,
                       input logic [2:0] f3, input logic [1:0] a, input logic [31:0] wd);
    idle_in();
    ex_valid_i = 1; ex_is_load_i = ld; ex_rd_i = rd; ex_wen_i = wen;
    ex_funct3_i = f3; ex_addr_i = a; ex_wdata_i = wd;
    cycle();
    idle_in();
  endtask

  task automatic respond(input logic [31:0] data);
    idle_in();
    mem_rvalid_i = 1; mem_rdata_i = data;
    cycle();
    idle_in();
  endtask

  initial begin
    m_busy = 0; m_rd = 0; m_wen = 0; m_f3 = 0; m_addr = 0;
    rst = 0;
    repeat (2) cycle();
    chk("reset_wen",   32'(reg_wen_o),    32'd0);
    chk("reset_ready", 32'(ex_ready_o),   32'd1);
    chk("reset_pend",  32'(pend_valid_o), 32'd0);
    rst = 1;
    cycle();

    // ALU write rd 5
    issue(0, 5'd5, 1, 3'd0, 2'd0, 32'h1234_5678);
    chk("alu_wen",   32'(reg_wen_o),   32'd1);
    chk("alu_waddr", 32'(reg_waddr_o), 32'd5);
    chk("alu_wdata", reg_wdata_o,      32'h1234_5678);

    // lb rd 7 addr 3, four stalled cycles, then response
    issue(1, 5'd7, 1, 3'd0, 2'd3, 32'd0);
    chk("lb_ready0", 32'(ex_ready_o), 32'd0);
    chk("lb_pend0",  32'(pend_rd_o),  32'd7);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lb_ready", 32'(ex_ready_o), 32'd0);
      chk("lb_pend",  32'(pend_rd_o),  32'd7);
    end
    respond(32'h80FF_0000);
    chk("lb_wen",   32'(reg_wen_o),   32'd1);
    chk("lb_waddr", 32'(reg_waddr_o), 32'd7);
    chk("lb_wdata", reg_wdata_o,      32'hFFFF_FF80);

    // lhu rd 9 addr 2 followed immediately by misaligned lw
    issue(1, 5'd9, 1, 3'd5, 2'd2, 32'd0);
    respond(32'hBEEF_1234);
    chk("lhu_wdata", reg_wdata_o, 32'h0000_BEEF);
    issue(1, 5'd4, 1, 3'd2, 2'd1, 32'd0);
    chk("lw_mis_err",   32'(err_o),      32'd1);
    chk("lw_mis_wen",   32'(reg_wen_o),  32'd0);
    chk("lw_mis_ready", 32'(ex_ready_o), 32'd1);

    // rd 0: ALU write suppressed; load still waits
    issue(0, 5'd0, 1, 3'd0, 2'd0, 32'hDEAD_BEEF);
    chk("x0_alu_wen", 32'(reg_wen_o), 32'd0);
    issue(1, 5'd0, 1, 3'd2, 2'd0, 32'd0);
    chk("x0_ld_pend", 32'(pend_valid_o), 32'd1);
    cycle();
    respond(32'h5555_AAAA);
    chk("x0_ld_wen",   32'(reg_wen_o),  32'd0);
    chk("x0_ld_ready", 32'(ex_ready_o), 32'd1);

    // Reset while waiting discards the load; later response is stray
    issue(1, 5'd3, 1, 3'd2, 2'd0, 32'd0);
    rst = 0;
    cycle();
    chk("rstw_pend", 32'(pend_valid_o), 32'd0);
    rst = 1;
    respond(32'h0BAD_F00D);
    chk("rstw_wen",  32'(reg_wen_o),    32'd0);
    chk("rstw_err",  32'(err_o),        32'd1);
    chk("rstw_pend2", 32'(pend_valid_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ex_valid_i   = ($urandom_range(0, 99) < 60);
      ex_is_load_i = ($urandom_range(0, 1) == 1);
      ex_rd_i      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ex_wen_i     = ($urandom_range(0, 9) != 0);
      ex_wdata_i   = $urandom;
      ex_funct3_i  = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                     (($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 1) * 4));
      ex_addr_i    = 2'($urandom);
      mem_rvalid_i = m_busy ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 5);
      mem_rdata_i  = $urandom;
      rst          = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1;
    idle_in();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_load_unit.md
WB_LOAD_UNIT -- requirements
Module: wb_load_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed (data 32, register index 5).
REQ-002 SHALL have: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have: ex_valid_i  in  1  execute stage presents a result this cycle.
REQ-005 SHALL have: ex_ready_o  out  1  unit accepts the presented result; high only in IDLE.
REQ-006 SHALL have: ex_rd_i  in  5  destination register index.
REQ-007 SHALL have: ex_wen_i  in  1  instruction writes rd.
REQ-008 SHALL have: ex_wdata_i  in  32  ALU result for non-load instructions.
REQ-009 SHALL have: ex_is_load_i  in  1  instruction is a load.
REQ-010 SHALL have: ex_funct3_i  in  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
REQ-011 SHALL have: ex_addr_i  in  2  low bits of the load byte address.
REQ-012 SHALL have: mem_rvalid_i  in  1  data memory read response valid (one-cycle pulse).
REQ-013 SHALL have: mem_rdata_i  in  32  aligned 32-bit memory word.
REQ-014 SHALL have: reg_waddr_o  out  5  register file write index.
REQ-015 SHALL have: reg_wdata_o  out  32  register file write data.
REQ-016 SHALL have: reg_wen_o  out  1  register file write enable, one cycle per write.
REQ-017 SHALL have: pend_valid_o  out  1  a load is outstanding (for ID-stage hazard stall).
REQ-018 SHALL have: pend_rd_o  out  5  rd of the outstanding load; 0 when none.
REQ-019 SHALL have: err_o  out  1  one-cycle pulse: misaligned/reserved load or stray response.

Function
REQ-020 SHALL implement states IDLE and WAIT_MEM; ex_ready_o = (state==IDLE), combinational.
REQ-021 Transfer SHALL occur when ex_valid_i && ex_ready_o.
REQ-022 Non-load transfer: next cycle reg_wen_o=ex_wen_i && rd!=0, reg_waddr_o=rd, reg_wdata_o=ex_wdata_i; latency 1; stay IDLE.
REQ-023 Legal load transfer: latch rd, wen, funct3, addr; go WAIT_MEM; no write issued.
REQ-024 Load legality: lh/lhu need addr[0]=0; lw needs addr=0; funct3 3,6,7 reserved.
REQ-025 Illegal load transfer: err_o=1 next cycle, no write, no WAIT_MEM, stay IDLE.
REQ-026 In WAIT_MEM: pend_valid_o=1, pend_rd_o=latched rd; otherwise both 0.
REQ-027 WAIT_MEM with mem_rvalid_i=1: next cycle write extracted data if latched wen && rd!=0; return to IDLE.
REQ-028 Extraction: lb/lbu byte mem_rdata_i[8*addr+7:8*addr]; lh/lhu half mem_rdata_i[16*addr[1]+15:16*addr[1]]; sign-extend lb/lh, zero-extend lbu/lhu; lw whole word.
REQ-029 mem_rvalid_i while IDLE SHALL be ignored (no write) and pulse err_o next cycle.
REQ-030 WAIT_MEM with mem_rvalid_i=0: hold all latched values indefinitely; no timeout.
REQ-031 reg_waddr_o/reg_wdata_o/reg_wen_o/err_o SHALL be registered; reg_wen_o high at most one cycle per instruction.
REQ-032 Cycle after load completion is IDLE; a new transfer is accepted then, back-to-back writes allowed.
REQ-033 When reg_wen_o=0, reg_waddr_o and reg_wdata_o SHALL be 0.

Reset
REQ-034 rst=0 at a clock edge: state IDLE; reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, err_o=0, pend_valid_o=0, pend_rd_o=0.
REQ-035 Reset during WAIT_MEM SHALL discard the outstanding load; no write for it is ever issued.
REQ-036 While rst=0, ex_ready_o SHALL be 1 (IDLE) but no transfer or write takes effect.

Verification
REQ-037 ALU op rd=5, wdata=0x1234_5678, wen=1 -> next cycle reg_wen_o=1, waddr=5, wdata=0x1234_5678.
REQ-038 lb rd=7 addr=3, rvalid 4 cycles later with rdata=0x80FF_0000 -> ex_ready_o=0 and pend_rd_o=7 for 4 cycles; then write rd 7 = 0xFFFF_FF80.
REQ-039 lhu rd=9 addr=2, rdata=0xBEEF_1234 -> write 0x0000_BEEF; lw addr=1 -> err_o pulse, no write, ex_ready_o stays 1.
REQ-040 ALU op rd=0 wen=1 -> no write; load rd=0 -> still waits for rvalid, no write, returns IDLE.
REQ-041 rst=0 asserted during WAIT_MEM, then rvalid pulse after release -> no write, err_o pulse, pend_valid_o=0.
